maxi_ordered_controller: RTL and testbench
==========================================

Name: maxi_ordered_controller

Overview:
- Next-generation PCIe-to-AXI4-Lite master bridge: accepts decoded PCIe memory-request TLP info, translates BAR-relative addresses to AXI addresses, issues AXI4-Lite reads and writes, and returns read data to the completion generator.
- Generalised in data width and BAR count. Supports multiple outstanding reads and writes, a runtime-selectable ordering mode and a read-data return FIFO with credit-based AR issue.
- Sits between the PCIe RX request decoder and the AXI-Lite interconnect; completion data feeds the TX completer.

Parameters:
- DATA_WIDTH, 32, AXI data width and request/completion data width; 32 or 64.
- ADDR_WIDTH, 32, AXI address width.
- NUM_BARS, 6, number of BARs translated (1..6).
- BAR_AXI, {6{64'h0}}, packed 64-bit AXI base per BAR; BAR n uses bits [64n+ADDR_WIDTH-1:64n].
- BAR_SIZE, {6{8'd12}}, packed 8-bit log2 aperture size per BAR.
- MAX_RD, 4, maximum reads in flight plus buffered; also the read FIFO depth (2..16).
- MAX_WR, 4, maximum writes awaiting B response (1..16).

Ports:
- m_axi_aclk  in  1  clock.
- m_axi_aresetn  in  1  asynchronous active-low reset.
- order_relaxed  in  1  0 = reads may not pass writes; 1 = independent. Sampled per request.
- m_axi_awaddr/awprot/awvalid/awready  out/out/out/in  ADDR_WIDTH/3/1/1  AXI-Lite AW channel.
- m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1  AXI-Lite W channel.
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  AXI-Lite B channel.
- m_axi_araddr/arprot/arvalid/arready  out/out/out/in  ADDR_WIDTH/3/1/1  AXI-Lite AR channel.
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  DATA_WIDTH/2/1/1  AXI-Lite R channel.
- mem_req_valid/mem_req_ready  in/out  1/1  request handshake.
- mem_req_bar_hit  in  3  BAR index.
- mem_req_pcie_address  in  32  PCIe byte address.
- mem_req_byte_enable  in  DATA_WIDTH/8  byte enables.
- mem_req_write_readn  in  1  1 = write, 0 = read.
- mem_req_write_data  in  DATA_WIDTH  write data.
- axi_cpld_valid/axi_cpld_ready  out/in  1/1  completion handshake.
- axi_cpld_data  out  DATA_WIDTH  read data.
- axi_cpld_err  out  1  read error flag; tied 0 unless ERR_RESP_EN.

Behaviour:
- Reset (async assert, sync release): all valids 0, all addr/data outputs 0, bready=1, rready=1, mem_req_ready=0 for 1 cycle after release, counters 0, FIFO empty.
- Translation: awaddr/araddr = {BAR_AXI[n] above bit BAR_SIZE[n], pcie_address[BAR_SIZE[n]-1:0]}.
  - 64-bit mode: address bits [2:0] are forced 0.
  - bar_hit >= NUM_BARS: request accepted and dropped; for reads, a completion with data all-ones is pushed.
- Counters:
  - rd_cnt = issued + buffered reads; increments on AR accept (arvalid & arready), decrements on completion pop (cpld valid & ready).
  - wr_cnt increments on request accept for writes, decrements on bvalid.
- Acceptance:
  - Read accepted when rd_cnt < MAX_RD, AR register free, and (order_relaxed | wr_cnt == 0).
  - Write accepted when wr_cnt < MAX_WR and AW/W registers free.
  - mem_req_ready is combinational on these conditions for the current write_readn.
- Write path: on accept, AW and W load in the same cycle; each valid holds until its own ready, independently. A register is free again the cycle after its handshake. B responses are counted, not ordered.
- Read path: on accept, arvalid=1 next cycle, held until arready. R beats push into the FIFO (rready=1 is guaranteed by the credit). The FIFO is first-word-fall-through; head drives axi_cpld_*.
- Simultaneous increment and decrement on a counter: net change 0.
- Completion order equals request order.
- awprot=arprot=3'b000.
- Reset mid-transaction: all state discarded; upstream must re-issue.

Optional Feature:
- Macro ERR_RESP_EN.
- Defined:
  - rresp != OKAY forces axi_cpld_data all-ones and axi_cpld_err=1 for that entry.
  - bresp != OKAY increments a saturating 8-bit wr_err_cnt, exposed on an extra output port wr_err_cnt[7:0].
- Undefined: rdata is passed unchanged, axi_cpld_err=0, and the wr_err_cnt port is absent.

Test Plan:
- BAR2 base 0x4000_0000, size 12; write addr 0x1234 data 0xDEADBEEF, be 0xF -> awaddr 0x4000_0234, wdata 0xDEADBEEF, wstrb 0xF; AW and W each complete with ready delayed 0 and 3 cycles.
- 4 reads back-to-back, MAX_RD=4, axi_cpld_ready=0 -> 4 ARs issued, 5th request ready=0; pop one completion -> ready=1 on the next cycle; data returned in issue order.
- order_relaxed=0, write with bvalid delayed 10 cycles followed by a read -> arvalid rises only after bvalid; order_relaxed=1 -> arvalid rises 1 cycle after accept.
- bar_hit=7, NUM_BARS=6, read -> no AR issued; completion 0xFFFFFFFF returned.
- With ERR_RESP_EN, rresp=2'b10, rdata=0x12345678 -> cpld_data 0xFFFFFFFF, err=1; 3 SLVERR B responses -> wr_err_cnt=3.
- Assert aresetn low with 2 reads and 1 write outstanding -> all valids 0 immediately; FIFO empty and counters 0 after release.

Source files
------------

// File: rtl/maxi_ordered_controller.sv
// PCIe memory-request to AXI4-Lite master bridge with BAR translation and in-order read completions.
// Optional macro ERR_RESP_EN: error responses become error completions and a saturating write error counter.
module maxi_ordered_controller #(
  parameter int              DATA_WIDTH = 32,
  parameter int              ADDR_WIDTH = 32,
  parameter int              NUM_BARS   = 6,
  parameter logic [6*64-1:0] BAR_AXI    = {6{64'h0}},
  parameter logic [6*8-1:0]  BAR_SIZE   = {6{8'd12}},
  parameter int              MAX_RD     = 4,
  parameter int              MAX_WR     = 4
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_aresetn,
  input  logic                    order_relaxed,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic                    mem_req_valid,
  output logic                    mem_req_ready,
  input  logic [2:0]              mem_req_bar_hit,
  input  logic [31:0]             mem_req_pcie_address,
  input  logic [DATA_WIDTH/8-1:0] mem_req_byte_enable,
  input  logic                    mem_req_write_readn,
  input  logic [DATA_WIDTH-1:0]   mem_req_write_data,
  output logic                    axi_cpld_valid,
  input  logic                    axi_cpld_ready,
  output logic [DATA_WIDTH-1:0]   axi_cpld_data,
  output logic                    axi_cpld_err
`ifdef ERR_RESP_EN
  ,
  output logic [7:0]              wr_err_cnt
`endif
);

  localparam int SW  = DATA_WIDTH / 8;
  localparam int RCW = $clog2(MAX_RD + 1);
  localparam int WCW = $clog2(MAX_WR + 1);
  localparam int PW  = $clog2(MAX_RD);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    (DATA_WIDTH == 64) ? ~{{(ADDR_WIDTH-3){1'b0}}, 3'b111} : {ADDR_WIDTH{1'b1}};

  logic                  init_q, init_d;
  logic                  aw_valid_q, aw_valid_d, w_valid_q, w_valid_d, ar_valid_q, ar_valid_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         wstrb_q, wstrb_d;
  logic [WCW-1:0]        wr_cnt_q, wr_cnt_d;
  logic [RCW-1:0]        rd_cnt_q, rd_cnt_d, fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_data_q [MAX_RD];
  logic                  mem_err_q  [MAX_RD];

  logic                  bar_ok_s, hit_v;
  logic [ADDR_WIDTH-1:0] xlat_raw_s, xlat_addr_s, mask_v, pcie_ext_s;
  logic                  wr_ok_s, rd_ok_s, acc_s, wr_fwd_s, rd_fwd_s, rd_drop_s;
  logic                  ar_hs_s, push_s, pop_s, push_err_s;
  logic [RCW-1:0]        rd_inflight_s;
  logic [DATA_WIDTH-1:0] push_data_s;

  assign pcie_ext_s = ADDR_WIDTH'(mem_req_pcie_address);

  // BAR decode and base/offset splice
  always_comb begin
    xlat_raw_s = '0;
    bar_ok_s   = 1'b0;
    mask_v     = '0;
    hit_v      = 1'b0;
    for (int i = 0; i < NUM_BARS; i++) begin
      mask_v     = ~({ADDR_WIDTH{1'b1}} << BAR_SIZE[8*i +: 8]);
      hit_v      = (mem_req_bar_hit == 3'(i));
      xlat_raw_s = hit_v ? ((BAR_AXI[64*i +: ADDR_WIDTH] & ~mask_v) | (pcie_ext_s & mask_v)) : xlat_raw_s;
      bar_ok_s   = bar_ok_s | hit_v;
    end
    xlat_addr_s = xlat_raw_s & ALIGN_MASK;
  end

  // A dropped read completes immediately, so it waits until no real read is still in flight
  assign rd_inflight_s = rd_cnt_q - fifo_cnt_q;
  assign wr_ok_s   = init_q & (wr_cnt_q < WCW'(MAX_WR)) & ~aw_valid_q & ~w_valid_q;
  assign rd_ok_s   = init_q & (rd_cnt_q < RCW'(MAX_RD)) & ~ar_valid_q &
                     (order_relaxed | (wr_cnt_q == '0)) & (bar_ok_s | (rd_inflight_s == '0));
  assign mem_req_ready = mem_req_write_readn ? wr_ok_s : rd_ok_s;

  assign acc_s     = mem_req_valid & mem_req_ready;
  assign wr_fwd_s  = acc_s & mem_req_write_readn & bar_ok_s;
  assign rd_fwd_s  = acc_s & ~mem_req_write_readn & bar_ok_s;
  assign rd_drop_s = acc_s & ~mem_req_write_readn & ~bar_ok_s;
  assign ar_hs_s   = ar_valid_q & m_axi_arready;
  assign push_s    = m_axi_rvalid | rd_drop_s;
  assign pop_s     = (fifo_cnt_q != '0) & axi_cpld_ready;

  // Completion entry contents for the pushed beat
  always_comb begin
    push_data_s = m_axi_rdata;
    push_err_s  = 1'b0;
    if (rd_drop_s) begin
      push_data_s = '1;
      push_err_s  = 1'b0;
    end
`ifdef ERR_RESP_EN
    else if (m_axi_rresp != 2'b00) begin
      push_data_s = '1;
      push_err_s  = 1'b1;
    end
`endif
    else begin
      push_data_s = m_axi_rdata;
      push_err_s  = 1'b0;
    end
  end

  // Next-state for channel registers, counters and FIFO pointers
  always_comb begin
    init_d     = 1'b1;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    araddr_d   = araddr_q;
    aw_valid_d = aw_valid_q & ~m_axi_awready;
    w_valid_d  = w_valid_q & ~m_axi_wready;
    ar_valid_d = ar_valid_q & ~m_axi_arready;
    if (wr_fwd_s) begin
      aw_valid_d = 1'b1;
      w_valid_d  = 1'b1;
      awaddr_d   = xlat_addr_s;
      wdata_d    = mem_req_write_data;
      wstrb_d    = mem_req_byte_enable;
    end else begin
      awaddr_d   = awaddr_q;
    end
    if (rd_fwd_s) begin
      ar_valid_d = 1'b1;
      araddr_d   = xlat_addr_s;
    end else begin
      araddr_d   = araddr_q;
    end
    wr_cnt_d   = wr_cnt_q + WCW'(wr_fwd_s) - WCW'(m_axi_bvalid);
    rd_cnt_d   = rd_cnt_q + RCW'(ar_hs_s | rd_drop_s) - RCW'(pop_s);
    fifo_cnt_d = fifo_cnt_q + RCW'(push_s) - RCW'(pop_s);
    wr_ptr_d   = push_s ? ((wr_ptr_q == PW'(MAX_RD - 1)) ? '0 : wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d   = pop_s  ? ((rd_ptr_q == PW'(MAX_RD - 1)) ? '0 : rd_ptr_q + PW'(1)) : rd_ptr_q;
  end

  // Control and channel state registers
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      init_q     <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      init_q     <= init_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      ar_valid_q <= ar_valid_d;
      awaddr_q   <= awaddr_d;
      araddr_q   <= araddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Completion FIFO storage
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      for (int i = 0; i < MAX_RD; i++) begin
        mem_data_q[i] <= '0;
        mem_err_q[i]  <= 1'b0;
      end
    end else if (push_s) begin
      mem_data_q[wr_ptr_q] <= push_data_s;
      mem_err_q[wr_ptr_q]  <= push_err_s;
    end
  end

`ifdef ERR_RESP_EN
  logic [7:0] wr_err_cnt_q, wr_err_cnt_d;

  // Saturating count of non-OKAY write responses
  always_comb begin
    if (m_axi_bvalid && (m_axi_bresp != 2'b00) && (wr_err_cnt_q != 8'hFF)) begin
      wr_err_cnt_d = wr_err_cnt_q + 8'd1;
    end else begin
      wr_err_cnt_d = wr_err_cnt_q;
    end
  end

  // Write error counter register
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      wr_err_cnt_q <= 8'd0;
    end else begin
      wr_err_cnt_q <= wr_err_cnt_d;
    end
  end

  assign wr_err_cnt = wr_err_cnt_q;
`else
  logic unused_resp_s;
  assign unused_resp_s = ^{m_axi_rresp, m_axi_bresp};
`endif

  assign m_axi_awaddr   = awaddr_q;
  assign m_axi_awprot   = 3'b000;
  assign m_axi_awvalid  = aw_valid_q;
  assign m_axi_wdata    = wdata_q;
  assign m_axi_wstrb    = wstrb_q;
  assign m_axi_wvalid   = w_valid_q;
  assign m_axi_bready   = 1'b1;
  assign m_axi_araddr   = araddr_q;
  assign m_axi_arprot   = 3'b000;
  assign m_axi_arvalid  = ar_valid_q;
  assign m_axi_rready   = 1'b1;
  assign axi_cpld_valid = (fifo_cnt_q != '0);
  assign axi_cpld_data  = mem_data_q[rd_ptr_q];
  assign axi_cpld_err   = mem_err_q[rd_ptr_q];

endmodule

// File: tb/tb_maxi_ordered_controller.sv
// Directed self-checking bench for maxi_ordered_controller (BAR0 at 0x2000_0000, BAR2 at 0x4000_0000).
module tb_maxi_ordered_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        order_relaxed;
  logic [31:0] awaddr, araddr, wdata, rdata, cpld_data, req_addr, req_data;
  logic [2:0]  awprot, arprot, req_bar;
  logic [3:0]  wstrb, req_be;
  logic [1:0]  bresp, rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic        req_valid, req_ready, req_wr;
  logic        cpld_valid, cpld_ready, cpld_err;
`ifdef ERR_RESP_EN
  logic [7:0]  wr_err_cnt;
`endif
  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  maxi_ordered_controller #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_BARS(6),
    .BAR_AXI({64'h0, 64'h0, 64'h0, 64'h4000_0000, 64'h0, 64'h2000_0000}),
    .BAR_SIZE({6{8'd12}}), .MAX_RD(4), .MAX_WR(4)
  ) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n), .order_relaxed(order_relaxed),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .mem_req_valid(req_valid), .mem_req_ready(req_ready), .mem_req_bar_hit(req_bar),
    .mem_req_pcie_address(req_addr), .mem_req_byte_enable(req_be), .mem_req_write_readn(req_wr),
    .mem_req_write_data(req_data),
    .axi_cpld_valid(cpld_valid), .axi_cpld_ready(cpld_ready), .axi_cpld_data(cpld_data),
    .axi_cpld_err(cpld_err)
`ifdef ERR_RESP_EN
    , .wr_err_cnt(wr_err_cnt)
`endif
  );

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait (bounded) for ready, and return one step after the accepting edge.
  task automatic send_req(input string tag, input logic [2:0] bar, input logic [31:0] addr,
                          input logic wr, input logic [31:0] data);
    int n;
    req_bar = bar; req_addr = addr; req_wr = wr; req_data = data; req_be = 4'hF;
    req_valid = 1'b1;
    #1;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      tick;
      n++;
    end
    check_vec({tag, "_rdy"}, 64'(req_ready), 64'd1);
    tick;
    req_valid = 1'b0;
  endtask

  task automatic pop_cpld(input string tag, input logic [31:0] exp_data);
    check_vec({tag, "_cv"}, 64'(cpld_valid), 64'd1);
    check_vec({tag, "_cd"}, 64'(cpld_data), 64'(exp_data));
    cpld_ready = 1'b1;
    tick;
    cpld_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int arv_seen;
    rst_n = 1'b0; order_relaxed = 1'b0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rresp = 2'b00; rdata = 32'h0;
    req_valid = 1'b0; req_bar = 3'd0; req_addr = 32'h0; req_be = 4'h0; req_wr = 1'b1; req_data = 32'h0;
    cpld_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check_vec("rst_awvalid", 64'(awvalid), 64'd0);
    check_vec("rst_wvalid", 64'(wvalid), 64'd0);
    check_vec("rst_arvalid", 64'(arvalid), 64'd0);
    check_vec("rst_cpldv", 64'(cpld_valid), 64'd0);
    check_vec("rst_bready", 64'(bready), 64'd1);
    check_vec("rst_rready", 64'(rready), 64'd1);
    check_vec("rst_awaddr", 64'(awaddr), 64'd0);
    check_vec("rst_cpld_data", 64'(cpld_data), 64'd0);
    rst_n = 1'b1;
    #1;
    check_vec("rdy_release", 64'(req_ready), 64'd0);
    tick;
    check_vec("rdy_after_1clk", 64'(req_ready), 64'd1);

    // BAR2 write, AW ready immediately, W ready 3 cycles later
    send_req("wr1", 3'd2, 32'h1234, 1'b1, 32'hDEADBEEF);
    check_vec("wr1_awvalid", 64'(awvalid), 64'd1);
    check_vec("wr1_awaddr", 64'(awaddr), 64'h4000_0234);
    check_vec("wr1_awprot", 64'(awprot), 64'd0);
    check_vec("wr1_wvalid", 64'(wvalid), 64'd1);
    check_vec("wr1_wdata", 64'(wdata), 64'hDEADBEEF);
    check_vec("wr1_wstrb", 64'(wstrb), 64'hF);
    awready = 1'b1;
    tick;
    awready = 1'b0;
    check_vec("wr1_aw_done", 64'(awvalid), 64'd0);
    check_vec("wr1_w_held", 64'(wvalid), 64'd1);
    check_vec("wr1_busy_rdy", 64'(req_ready), 64'd0);
    tick; tick;
    check_vec("wr1_w_held2", 64'(wvalid), 64'd1);
    wready = 1'b1;
    tick;
    wready = 1'b0;
    check_vec("wr1_w_done", 64'(wvalid), 64'd0);
    check_vec("wr1_free_rdy", 64'(req_ready), 64'd1);
    bvalid = 1'b1;
    tick;
    bvalid = 1'b0;

    // Strict ordering: read waits for the write's B response
    awready = 1'b1; wready = 1'b1; arready = 1'b1; order_relaxed = 1'b0;
    send_req("ow", 3'd0, 32'h10, 1'b1, 32'h1111_2222);
    req_bar = 3'd0; req_addr = 32'h20; req_wr = 1'b0; req_valid = 1'b1;
    #1;
    check_vec("ord0_blk", 64'(req_ready), 64'd0);
    arv_seen = 0;
    repeat (10) begin
      tick;
      if (arvalid) arv_seen++;
    end
    check_vec("ord0_no_ar", 64'(arv_seen), 64'd0);
    bvalid = 1'b1;
    tick;
    bvalid = 1'b0;
    check_vec("ord0_ar_before", 64'(arvalid), 64'd0);
    check_vec("ord0_rdy", 64'(req_ready), 64'd1);
    tick;
    req_valid = 1'b0;
    check_vec("ord0_ar_after", 64'(arvalid), 64'd1);
    check_vec("ord0_araddr", 64'(araddr), 64'h2000_0020);
    tick;
    check_vec("ord0_ar_done", 64'(arvalid), 64'd0);
    rvalid = 1'b1; rdata = 32'hA5A5_0001;
    tick;
    rvalid = 1'b0;
    check_vec("ord0_err", 64'(cpld_err), 64'd0);
    pop_cpld("ord0", 32'hA5A5_0001);
    check_vec("ord0_empty", 64'(cpld_valid), 64'd0);

    // Relaxed ordering: read passes the outstanding write
    order_relaxed = 1'b1;
    send_req("rw", 3'd0, 32'h30, 1'b1, 32'h3333_4444);
    req_bar = 3'd0; req_addr = 32'h40; req_wr = 1'b0; req_valid = 1'b1;
    #1;
    check_vec("ord1_rdy", 64'(req_ready), 64'd1);
    tick;
    req_valid = 1'b0;
    check_vec("ord1_ar", 64'(arvalid), 64'd1);
    check_vec("ord1_araddr", 64'(araddr), 64'h2000_0040);
    tick;
    rvalid = 1'b1; rdata = 32'hA5A5_0002;
    tick;
    rvalid = 1'b0; bvalid = 1'b1;
    tick;
    bvalid = 1'b0;
    pop_cpld("ord1", 32'hA5A5_0002);

    // Four reads fill the credit; a fifth waits until one completion pops
    order_relaxed = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send_req("rd4", 3'd2, 32'h100 * k, 1'b0, 32'h0);
      check_vec("rd4_ar", 64'(arvalid), 64'd1);
      check_vec("rd4_araddr", 64'(araddr), 64'h4000_0000 + 64'(32'h100 * k));
      tick;
      rvalid = 1'b1; rdata = 32'hC0DE_0000 + 32'(k);
      tick;
      rvalid = 1'b0;
    end
    req_bar = 3'd2; req_addr = 32'h500; req_wr = 1'b0; req_valid = 1'b1;
    #1;
    check_vec("rd5_blk", 64'(req_ready), 64'd0);
    tick;
    check_vec("rd5_blk2", 64'(req_ready), 64'd0);
    check_vec("rd5_no_ar", 64'(arvalid), 64'd0);
    pop_cpld("rd4_0", 32'hC0DE_0000);
    check_vec("rd5_rdy", 64'(req_ready), 64'd1);
    tick;
    req_valid = 1'b0;
    check_vec("rd5_araddr", 64'(araddr), 64'h4000_0500);
    tick;
    rvalid = 1'b1; rdata = 32'hC0DE_0004;
    tick;
    rvalid = 1'b0;
    for (int k = 1; k < 5; k++) pop_cpld("rd4_n", 32'hC0DE_0000 + 32'(k));
    check_vec("rd4_empty", 64'(cpld_valid), 64'd0);

    // Unmapped BAR: read completes with all-ones, write is dropped
    send_req("drop", 3'd7, 32'h44, 1'b0, 32'h0);
    check_vec("drop_no_ar", 64'(arvalid), 64'd0);
    check_vec("drop_err", 64'(cpld_err), 64'd0);
    pop_cpld("drop", 32'hFFFF_FFFF);
    send_req("dropw", 3'd6, 32'h8, 1'b1, 32'h5555_6666);
    check_vec("dropw_no_aw", 64'(awvalid), 64'd0);
    check_vec("dropw_no_w", 64'(wvalid), 64'd0);

`ifdef ERR_RESP_EN
    send_req("rerr", 3'd0, 32'h50, 1'b0, 32'h0);
    tick;
    rvalid = 1'b1; rresp = 2'b10; rdata = 32'h1234_5678;
    tick;
    rvalid = 1'b0; rresp = 2'b00;
    check_vec("rerr_err", 64'(cpld_err), 64'd1);
    pop_cpld("rerr", 32'hFFFF_FFFF);
    for (int k = 0; k < 3; k++) send_req("werr", 3'd0, 32'h60 + 32'(4 * k), 1'b1, 32'h0);
    tick;
    bresp = 2'b10; bvalid = 1'b1;
    repeat (3) tick;
    bvalid = 1'b0; bresp = 2'b00;
    check_vec("werr_cnt", 64'(wr_err_cnt), 64'd3);
`endif

    // Reset with two reads and one write outstanding
    order_relaxed = 1'b1; arready = 1'b1;
    send_req("mr1", 3'd0, 32'h70, 1'b0, 32'h0);
    tick;
    arready = 1'b0;
    send_req("mr2", 3'd0, 32'h74, 1'b0, 32'h0);
    awready = 1'b0; wready = 1'b0;
    send_req("mw", 3'd0, 32'h78, 1'b1, 32'h7777_8888);
    check_vec("mid_ar_pend", 64'(arvalid), 64'd1);
    check_vec("mid_aw_pend", 64'(awvalid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("mid_rst_aw", 64'(awvalid), 64'd0);
    check_vec("mid_rst_w", 64'(wvalid), 64'd0);
    check_vec("mid_rst_ar", 64'(arvalid), 64'd0);
    check_vec("mid_rst_cv", 64'(cpld_valid), 64'd0);
    tick;
    rst_n = 1'b1;
    tick;
    order_relaxed = 1'b0;
    send_req("post_rst", 3'd7, 32'h0, 1'b0, 32'h0);
    pop_cpld("post_rst", 32'hFFFF_FFFF);
    check_vec("post_rst_empty", 64'(cpld_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
